tap_session_controller: RTL

//  Sequences the relay of the touchless tap from the raw IR presence signal.
//  - Synchronises and debounces the IR input.
//  - Keeps water flowing for a hold time after the hand leaves.
//  - Caps each session with an anti-flood timeout, then a lockout.
//  - Sits between IR_SENSOR and the relay driver; relay_out drives the valve.

---
 rtl/tap_ctrl_pkg.sv | 27 ++
 rtl/tap_debounce.sv | 47 ++++
 rtl/tap_session_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tap_ctrl_pkg.sv
// Shared definitions for the touchless tap session controller:
// FSM state encoding, state width and counter-width / saturation helpers.
package tap_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE       = 3'd0,
      ON         = 3'd1,
      HOLD       = 3'd2,
      LOCKOUT    = 3'd3,
      WAIT_CLEAR = 3'd4
   } tap_state_t;

   // True when a counter of width w can represent the value cyc-1 (the
   // largest value any timer is compared against).
   function automatic bit cnt_fits(input int unsigned cyc, input int unsigned w);
      if (w >= 32) return 1'b1;
      return (cyc - 1) < (32'd1 << w);
   endfunction

   // 16-bit increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/tap_debounce.sv
// Two-flop synchroniser followed by a stability filter. presence_db only
// follows the synchronised IR level after that level has differed from it
// for DEBOUNCE_CYC consecutive cycles; any return to the old level restarts
// the count.
module tap_debounce
   import tap_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000,
   parameter int CNT_W        = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic ir_sensor_raw,
   output logic presence_db
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] db_cnt;

   // Synchronise the asynchronous IR level and filter it for stability.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         presence_db <= 1'b0;
         db_cnt      <= '0;
      end else begin
         sync1 <= ir_sensor_raw;
         sync2 <= sync1;
         if (sync2 != presence_db) begin
            if (db_cnt == DB_LAST) begin
               presence_db <= sync2;
               db_cnt      <= '0;
            end else begin
               db_cnt <= db_cnt + CNT_ONE;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/tap_session_controller.sv
// Touchless tap session controller: debounced IR presence opens the valve,
// a hold time keeps it open after the hand leaves, and a per-session cap
// forces a lockout followed by a wait for the hand to clear.
// Optional feature macro: TAP_SESSION_COUNT_EN adds session_cnt_o, a
// saturating count of completed sessions.
module tap_session_controller
   import tap_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000,
   parameter int HOLD_CYC     = 50000,
   parameter int MAX_ON_CYC   = 1000000,
   parameter int LOCKOUT_CYC  = 100000,
   parameter int CNT_W        = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ir_sensor_raw,
   input  logic               enable,
   output logic               relay_out,
   output logic [STATE_W-1:0] state_o,
   output logic               timeout_o
`ifdef TAP_SESSION_COUNT_EN
   ,
   output logic [15:0]        session_cnt_o
`endif
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] MAX_ON_LAST = CNT_W'(MAX_ON_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCKOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   if (!cnt_fits(DEBOUNCE_CYC, CNT_W) || !cnt_fits(HOLD_CYC, CNT_W) ||
       !cnt_fits(MAX_ON_CYC, CNT_W)   || !cnt_fits(LOCKOUT_CYC, CNT_W)) begin : g_cnt_w_check
      $error("tap_session_controller: CNT_W too small for the configured cycle counts");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   logic             presence_db;
   tap_state_t       state;
   logic [CNT_W-1:0] on_timer;
   logic [CNT_W-1:0] hold_timer;
   logic [CNT_W-1:0] lock_timer;

   tap_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_debounce (
      .clk           (clk),
      .reset         (reset),
      .ir_sensor_raw (ir_sensor_raw),
      .presence_db   (presence_db)
   );

   assign state_o = state;

   // Session FSM with its timers; relay_out is registered alongside the state
   // so it is 1 exactly when the state is ON or HOLD.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         relay_out  <= 1'b0;
         timeout_o  <= 1'b0;
         on_timer   <= '0;
         hold_timer <= '0;
         lock_timer <= '0;
`ifdef TAP_SESSION_COUNT_EN
         session_cnt_o <= '0;
`endif
      end else if (!enable) begin
         state     <= IDLE;
         relay_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (presence_db) begin
                  state     <= ON;
                  relay_out <= 1'b1;
                  on_timer  <= '0;
               end
            end
            ON: begin
               if (on_timer == MAX_ON_LAST) begin
                  state      <= LOCKOUT;
                  relay_out  <= 1'b0;
                  timeout_o  <= 1'b1;
                  lock_timer <= '0;
`ifdef TAP_SESSION_COUNT_EN
                  session_cnt_o <= sat_inc16(session_cnt_o);
`endif
               end else begin
                  on_timer <= sat_inc(on_timer);
                  if (!presence_db) begin
                     state      <= HOLD;
                     hold_timer <= '0;
                  end
               end
            end
            HOLD: begin
               // The session cap is shared with ON and beats presence changes.
               if (on_timer == MAX_ON_LAST) begin
                  state      <= LOCKOUT;
                  relay_out  <= 1'b0;
                  timeout_o  <= 1'b1;
                  lock_timer <= '0;
`ifdef TAP_SESSION_COUNT_EN
                  session_cnt_o <= sat_inc16(session_cnt_o);
`endif
               end else begin
                  on_timer <= sat_inc(on_timer);
                  if (presence_db) begin
                     // Returning hand beats hold expiry in the same cycle.
                     state <= ON;
                  end else if (hold_timer == HOLD_LAST) begin
                     state     <= IDLE;
                     relay_out <= 1'b0;
`ifdef TAP_SESSION_COUNT_EN
                     session_cnt_o <= sat_inc16(session_cnt_o);
`endif
                  end else begin
                     hold_timer <= sat_inc(hold_timer);
                  end
               end
            end
            LOCKOUT: begin
               relay_out <= 1'b0;
               if (lock_timer == LOCK_LAST) begin
                  state <= WAIT_CLEAR;
               end else begin
                  lock_timer <= sat_inc(lock_timer);
               end
            end
            WAIT_CLEAR: begin
               // A hand held in place never re-opens the valve.
               relay_out <= 1'b0;
               if (!presence_db) begin
                  state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               relay_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
